// File: rtl/arb_grant_port_if.sv
// Shared slave-port handshake between the grant port (master side) and the downstream slave.
interface arb_grant_port_if #(parameter int W = 8);
  logic         bus_valid;
  logic [W-1:0] bus_data;
  logic         bus_ready;

  modport master (output bus_valid, output bus_data, input bus_ready);
  modport slave  (input bus_valid, input bus_data, output bus_ready);
endinterface

// File: rtl/arb_grant_port.sv
// Latches the one-hot granted master as owner and streams a fixed-length burst of its
// words onto the shared slave port, signalling done/abort/grant_err back upstream.
module arb_grant_port #(
  parameter int W         = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           grant,
  input  logic [4*W-1:0]       data_in,
  arb_grant_port_if.master     bus,
  output logic [1:0]           owner,
  output logic [3:0]           done,
  output logic                 abort,
  output logic                 grant_err
);
  localparam int         NUM_M   = 4;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] XFER    = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  localparam logic [3:0] LAST    = 4'(BURST_LEN - 1);

  logic [NUM_M-1:0][W-1:0] words;
  logic [1:0]              state;
  logic [3:0]              beat_cnt;
  logic [W-1:0]            data_q;
  logic [1:0]              enc;
  logic                    multi_hot, one_hot, gown, acc;

  assign words = data_in;

  always_comb begin
    enc = '0;
    for (int k = 0; k < NUM_M; k++)
      if (grant[k]) enc = 2'(k);
  end

  assign multi_hot = (grant != 4'd0) && ((grant & (grant - 4'd1)) != 4'd0);
  assign one_hot   = (grant != 4'd0) && !multi_hot;
  assign gown      = grant[owner];
  assign acc       = (state == XFER) && bus.bus_ready;

  assign bus.bus_valid = (state == XFER);
  assign bus.bus_data  = data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= '0;
      beat_cnt  <= '0;
      data_q    <= '0;
      done      <= '0;
      abort     <= 1'b0;
      grant_err <= 1'b0;
    end else begin
      done      <= '0;
      abort     <= 1'b0;
      grant_err <= multi_hot;
      case (state)
        IDLE: begin
          if (one_hot) begin
            owner    <= enc;
            data_q   <= words[enc];
            beat_cnt <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          // An accepted beat takes priority over a dropped grant, so a final
          // handshake coincident with the drop still completes the burst.
          if (acc) begin
            if (beat_cnt == LAST) begin
              done  <= 4'd1 << owner;
              state <= RELEASE;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
              data_q   <= words[owner];
            end
          end else if (!gown) begin
            abort <= 1'b1;
            state <= IDLE;
          end
        end
        RELEASE: begin
          if (!gown) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
